// File: rtl/serial_subtractor_8b.sv
// Bit-serial LSB-first subtractor: D = x - y - Bin over WIDTH cycles using one
// full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor_8b #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_r_next;

  always_comb begin
    w_d       = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_r_next  = {w_d, r_r[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= x;
            r_b     <= y;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_a  <= r_a >> 1;
          r_b  <= r_b >> 1;
          r_br <= w_br_next;
          r_r  <= w_r_next;
          // Last bit: publish the full result straight from the shift path.
          if (r_cnt == LastCnt) begin
            r_d     <= w_r_next;
            r_bout  <= w_br_next;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_8b.sv
// Directed bench for serial_subtractor_8b: hand-computed vectors checked with
// immediate assertions, sampled on the falling clock edge.
module tb_serial_subtractor_8b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       Bout;

  int         n_vec;
  int         n_bad;
  logic [7:0] last_d;
  logic       last_b;

  serial_subtractor_8b #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .y    (y),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .D    (D),
    .Bout (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE (called at a falling edge). mode 1 scribbles
  // on the inputs every cycle and pulses start during the 3rd busy cycle.
  task automatic op(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                    input logic [7:0] ed, input logic eb, input int mode, input string tag);
    int         busy_n = 0;
    int         done_n = 0;
    int         done_at = 0;
    int         hold_bad = 0;
    logic [7:0] dv = 'x;
    logic       bo = 1'bx;
    x = xv; y = yv; Bin = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        dv = D;
        bo = Bout;
      end else if (D !== last_d || Bout !== last_b) begin
        hold_bad++;
      end
      if (mode == 1) begin
        x = 8'($urandom);
        y = 8'($urandom);
        Bin = 1'($urandom);
        start = (i == 3);
        if (i == 3) begin x = 8'd1; y = 8'd2; end
      end
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_at), 32'd9);
    check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_D"}, 32'(dv), 32'(ed));
    check({tag, "_Bout"}, 32'(bo), 32'(eb));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    last_d = ed;
    last_b = eb;
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    int d_bad;
    int first_done;
    int gap_bad;
    int prev_done;

    n_vec = 0; n_bad = 0;
    last_d = 8'd0; last_b = 1'b0;
    rst_n = 1'b0; start = 1'b0; x = 8'd0; y = 8'd0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 0, "10m3");
    op(8'd0, 8'd1, 1'b0, 8'd255, 1'b1, 0, "0m1");
    op(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 0, "ffmffm1");
    op(8'd8, 8'd1, 1'b1, 8'd6, 1'b0, 0, "8m1m1");
    op(8'd255, 8'd0, 1'b0, 8'd255, 1'b0, 0, "ffm0");
    op(8'd0, 8'd255, 1'b1, 8'd0, 1'b1, 0, "0mffm1");
    op(8'd77, 8'd77, 1'b0, 8'd0, 1'b0, 0, "eq");
    op(8'd100, 8'd50, 1'b0, 8'd50, 1'b0, 1, "ignore_start");

    // Reset during the 4th busy cycle aborts the operation.
    x = 8'd200; y = 8'd100; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_D", 32'(D), 32'd0);
    check("abort_Bout", 32'(Bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("abort_no_busy", 32'(busy_seen), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'd0);
    last_d = 8'd0; last_b = 1'b0;
    op(8'd5, 8'd9, 1'b0, 8'd252, 1'b1, 0, "5m9");

    // start held high: back-to-back operations, done every 10 cycles.
    x = 8'd20; y = 8'd5; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    done_seen = 0; d_bad = 0; first_done = 0; gap_bad = 0; prev_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        done_seen++;
        if (D !== 8'd15 || Bout !== 1'b0) d_bad++;
        if (prev_done == 0) first_done = i;
        else if (i - prev_done != 10) gap_bad++;
        prev_done = i;
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(done_seen), 32'd3);
    check("held_first_done", 32'(first_done), 32'd9);
    check("held_gap", 32'(gap_bad), 32'd0);
    check("held_D", 32'(d_bad), 32'd0);
    repeat (2) @(negedge clk);
    check("held_stop_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_8b.md
Name: serial_subtractor_8b

Overview:
- Bit-serial, LSB-first subtractor with borrow. Computes D = x - y - Bin over WIDTH clock cycles using a single full-subtractor cell plus shift registers.
- Functional inverse of the team's 8-bit ripple adder (x, y, Cin -> sum, Cout).
- Serves as a low-area arithmetic unit in the embedded exercises datapath. Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- x  input  WIDTH  minuend; sampled on the accepting edge only.
- y  input  WIDTH  subtrahend; sampled on the accepting edge only.
- Bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress (SHIFT and DONE states).
- done  output  1  one-cycle pulse; D and Bout are valid and newly updated.
- D  output  WIDTH  difference, registered.
- Bout  output  1  borrow-out, registered (1 when x < y + Bin, unsigned).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, D=0, Bout=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Asserting reset mid-operation aborts the operation with no done pulse.
  - Operation resumes on the first rising edge after rst_n deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On a rising edge with start=1: latch x->A, y->B, Bin->br; clear cnt; go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT: busy=1. On each rising edge:
  - Full-subtractor cell: d = A[0] ^ B[0] ^ br.
  - Next borrow: br_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br).
  - A and B shift right by one; d shifts into the MSB of the result register R.
  - cnt increments.
  - On the edge where cnt == WIDTH-1: the final bit is processed, then D <= complete R (including that bit), Bout <= br_next, and the FSM goes to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - The next edge goes to IDLE unconditionally.
- Latency:
  - The edge that samples start is E0; done is high during the cycle following edge E(WIDTH), i.e. WIDTH+1 edges after acceptance.
  - Throughput: one operation per WIDTH+2 cycles.
- Handshake rules:
  - start is ignored in SHIFT and DONE; there is no queuing.
  - x, y and Bin may change freely after acceptance without affecting the result.
  - A start held high continuously restarts on the first edge in IDLE after DONE.
- Output hold:
  - D and Bout change only on the edge entering DONE, or on reset.
  - They hold their value through the following IDLE period and the next operation until the next completion.
- Arithmetic:
  - Result is modulo 2^WIDTH; Bout is the unsigned borrow.
  - Equivalently, {Bout, D} equals (x - y - Bin) taken modulo 2^(WIDTH+1).
- Boundary cases:
  - x=0, y=2^WIDTH-1, Bin=1 gives D=0, Bout=1.
  - x=y with Bin=0 gives D=0, Bout=0.
  - The counter never exceeds WIDTH-1; there is no wrap-around into another operation.

Test Plan:
- Reset, then x=10, y=3, Bin=0, start pulse -> busy high for 9 cycles; done pulse on the 9th cycle after the accepting edge; D=7, Bout=0.
- x=0, y=1, Bin=0 -> D=255 (8'hFF), Bout=1. Then x=255, y=255, Bin=1 -> D=255, Bout=1.
- x=8, y=1, Bin=1 -> D=6, Bout=0. Then x=255, y=0, Bin=0 -> D=255, Bout=0. D holds 6 between the two operations until the second done.
- Start x=100, y=50, Bin=0; on the 3rd busy cycle pulse start with x=1, y=2; change x and y every cycle -> the second start is ignored; D=50, Bout=0; exactly one done pulse.
- Start x=200, y=100; drop rst_n for 1 cycle on the 4th busy cycle -> busy=0, done=0, D=0, Bout=0 immediately. No done pulse follows. A fresh x=5, y=9 after reset -> D=252, Bout=1.
- Hold start=1 continuously with x=20, y=5 -> back-to-back operations; done pulses every 10 cycles; D=15 each time.
